// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD write-port arbiter.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_KBD = 1'b1;

  // 40 us at 50 MHz between LCD character writes
  localparam int DEF_GAP_CYCLES = 2000;

  // Round-robin choice: a lone requester wins, a tie goes to whoever was not served last
  function automatic logic pick_grant(input logic cpu_pend,
                                      input logic kbd_pend,
                                      input logic last_grant);
    logic g;
    if (cpu_pend && kbd_pend) g = ~last_grant;
    else if (cpu_pend)        g = GRANT_CPU;
    else                      g = GRANT_KBD;
    return g;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_slot.sv
// Single-entry hold buffer: pending flag plus character register.
// The slot takes a new character when empty or when it is being drained in
// the same cycle, so a requester can refill it on the write-strobe cycle.
module req_hold_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_drain,
  output logic              o_pending,
  output logic [DATA_W-1:0] o_data,
  output logic              o_accept
);

  logic              r_pending;
  logic [DATA_W-1:0] r_data;
  logic              w_take;

  assign o_accept  = ~r_pending | i_drain;
  assign w_take    = i_load & o_accept;
  assign o_pending = r_pending;
  assign o_data    = r_data;

  // Pending flag: set on capture, cleared when drained without a refill
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_pending <= 1'b0;
    else if (w_take)  r_pending <= 1'b1;
    else if (i_drain) r_pending <= 1'b0;
  end

  // Character register: only meaningful while the pending flag is set
  always_ff @(posedge clock) begin
    if (w_take) r_data <= i_data;
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD controller's character-write port between the processor
// (level req/ack) and the PS2 keyboard echo (one-cycle pulse). Each side has
// a one-character hold slot; grants alternate on ties and successive LCD
// strobes are separated by at least GAP_CYCLES clocks.
module lcd_write_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              kbd_valid,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              kbd_drop,
  output logic              lcd_wr_en,
  output logic [DATA_W-1:0] lcd_wr_data,
  output logic              busy
);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_cpu_ack;
  logic              r_kbd_drop;

  logic              w_cpu_load, w_cpu_accept, w_cpu_pend, w_cpu_drain;
  logic              w_kbd_accept, w_kbd_pend, w_kbd_drain;
  logic [DATA_W-1:0] w_cpu_data, w_kbd_data;
  logic              w_grant;

  // A held cpu_req is not re-captured on the ack cycle itself
  assign w_cpu_load  = cpu_req & ~r_cpu_ack;
  // last_grant was latched on entry to ISSUE, so it names the slot being written
  assign w_cpu_drain = (r_state == ST_ISSUE) && (r_last_grant == GRANT_CPU);
  assign w_kbd_drain = (r_state == ST_ISSUE) && (r_last_grant == GRANT_KBD);
  assign w_grant     = pick_grant(w_cpu_pend, w_kbd_pend, r_last_grant);

  req_hold_slot #(.DATA_W(DATA_W)) u_cpu_slot (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_cpu_load),
    .i_data    (cpu_data),
    .i_drain   (w_cpu_drain),
    .o_pending (w_cpu_pend),
    .o_data    (w_cpu_data),
    .o_accept  (w_cpu_accept)
  );

  req_hold_slot #(.DATA_W(DATA_W)) u_kbd_slot (
    .clock     (clock),
    .reset     (reset),
    .i_load    (kbd_valid),
    .i_data    (kbd_data),
    .i_drain   (w_kbd_drain),
    .o_pending (w_kbd_pend),
    .o_data    (w_kbd_data),
    .o_accept  (w_kbd_accept)
  );

  // Handshake pulses: ack a processor capture, flag a keystroke that found its slot full
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpu_ack  <= 1'b0;
      r_kbd_drop <= 1'b0;
    end else begin
      r_cpu_ack  <= w_cpu_load & w_cpu_accept;
      r_kbd_drop <= kbd_valid & ~w_kbd_accept;
    end
  end

  // Arbiter FSM: grant in IDLE, strobe for one cycle in ISSUE, then hold off for the gap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GRANT_KBD;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cpu_pend || w_kbd_pend) begin
            r_wr_data    <= (w_grant == GRANT_CPU) ? w_cpu_data : w_kbd_data;
            r_last_grant <= w_grant;
            r_wr_en      <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= GAP_LOAD;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == '0) r_state <= ST_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ack     = r_cpu_ack;
  assign kbd_drop    = r_kbd_drop;
  assign lcd_wr_en   = r_wr_en;
  assign lcd_wr_data = r_wr_data;
  assign busy        = (r_state != ST_IDLE) | w_cpu_pend | w_kbd_pend;

endmodule
